ca_hybrid_engine: RTL
=====================

CA_HYBRID_ENGINE -- requirements
Module: ca_hybrid_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of CA cells (min 3).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the step-counter width.
REQ-003 The block SHALL have parameter BOUNDARY, default 0: 0 = null boundary (out-of-range neighbour reads 0), 1 = periodic (cell 0 and cell WIDTH-1 are neighbours).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port load, input, 1 bit: write seed into the state register.
REQ-007 The block SHALL have port seed, input, WIDTH bits: initial CA state.
REQ-008 The block SHALL have port rule, input, WIDTH bits: per-cell rule select, 1 = rule 150, 0 = rule 90.
REQ-009 The block SHALL have port start, input, 1 bit: begin a run.
REQ-010 The block SHALL have port steps, input, CNT_W bits: number of CA steps for the run.
REQ-011 The block SHALL have port absorb_valid, input, 1 bit: XOR absorb_data into the current step.
REQ-012 The block SHALL have port absorb_data, input, WIDTH bits: data to absorb.
REQ-013 The block SHALL have port state, output, WIDTH bits: current CA state, registered.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse when a run completes.

Function
REQ-016 Cell i SHALL have left neighbour i-1 and right neighbour i+1.
REQ-017 The rule-90 next value SHALL be left^right; the rule-150 next value SHALL be left^self^right.
REQ-018 The FSM SHALL have states IDLE, RUN and DONE.
REQ-019 In IDLE with load=1, state SHALL take seed at the clock edge; start is ignored that cycle, since load has priority.
REQ-020 In IDLE with start=1 and load=0, the block SHALL latch rule and steps.
REQ-021 After that latch, the FSM SHALL go to RUN if steps>0, else to DONE.
REQ-022 In RUN, each edge SHALL apply one step to all cells in parallel and decrement the counter.
REQ-023 The edge that applies the last step SHALL move the FSM to DONE.
REQ-024 For start accepted at edge E0 with steps=N>0, steps SHALL be applied at edges E1..EN.
REQ-025 busy SHALL be high from after E0 through EN.
REQ-026 done SHALL be high for exactly the cycle after EN, and the FSM SHALL return to IDLE at EN+1.
REQ-027 For steps=0, busy SHALL stay 0, done SHALL pulse the cycle after E0, and state SHALL be unchanged.
REQ-028 In RUN with absorb_valid=1, next state SHALL be step(state)^absorb_data; absorb_valid SHALL be ignored outside RUN.
REQ-029 load, start, rule and steps SHALL be ignored in RUN and DONE; the latched rule SHALL govern the whole run.
REQ-030 The counter SHALL never wrap: the maximum run is 2^CNT_W-1 steps.
REQ-031 state SHALL hold its value in IDLE and DONE unless load is applied in IDLE.

Reset
REQ-032 When reset=1, asynchronously: state=0, busy=0, done=0, counter=0, latched rule=0, FSM=IDLE.
REQ-033 A reset mid-RUN SHALL abort the run with no done pulse.
REQ-034 After reset deassertion, the first accepted operation SHALL be a load or start in IDLE.

Structure
REQ-035 Package ca_pkg SHALL hold the FSM state enum and the boundary constants BND_NULL=0 and BND_PERIODIC=1.
REQ-036 Sub-module ca_cell SHALL compute the one-cell next value from left, self, right and rule bit, instantiated WIDTH times via generate.
REQ-037 The FSM, counter and absorb XOR SHALL reside in ca_hybrid_engine.

Verification (WIDTH=8, CNT_W=8)
REQ-038 Null boundary, rule=8'h00, seed 8'h01, steps=1 -> state=8'h02, done one cycle after step; the same with BOUNDARY=1 -> state=8'h82.
REQ-039 Null boundary, rule=8'h00, seed 8'h01, steps=2 -> state=8'h05 at E2, busy high two cycles, done high in the cycle after E2.
REQ-040 Null boundary, rule=8'hFF, seed 8'h01, steps=1 -> state=8'h03.
REQ-041 Seed 8'h00, rule=8'h00, steps=1, absorb_valid=1 with absorb_data=8'hA5 during RUN -> state=8'hA5.
REQ-042 steps=0 -> done pulses, busy stays 0, state unchanged.
REQ-043 load and start asserted together -> state=seed, FSM stays IDLE, no done.
REQ-044 Seed 8'h01, steps=5, reset asserted mid-RUN -> state=0, busy=0 immediately, no done.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types for the hybrid rule-90/150 cellular automaton engine:
// FSM state encoding and boundary-mode constants.
package ca_pkg;

    localparam int BND_NULL     = 0;
    localparam int BND_PERIODIC = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

endpackage

// File: rtl/ca_hybrid_engine_if.sv
// Control/status bundle for ca_hybrid_engine; master drives commands,
// slave returns the CA state and run status.
interface ca_hybrid_engine_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] rule;
    logic             start;
    logic [CNT_W-1:0] steps;
    logic             absorb_valid;
    logic [WIDTH-1:0] absorb_data;
    logic [WIDTH-1:0] state;
    logic             busy;
    logic             done;

    modport master (
        output load, seed, rule, start, steps, absorb_valid, absorb_data,
        input  state, busy, done
    );

    modport slave (
        input  load, seed, rule, start, steps, absorb_valid, absorb_data,
        output state, busy, done
    );
endinterface

// File: rtl/ca_cell.sv
// One CA cell: rule 90 (left^right) or rule 150 (left^self^right),
// selected by the per-cell rule bit.
module ca_cell (
    input  logic i_left,
    input  logic i_self,
    input  logic i_right,
    input  logic i_rule,
    output logic o_next
);
    assign o_next = i_left ^ i_right ^ (i_rule & i_self);
endmodule

// File: rtl/ca_hybrid_engine.sv
// Hybrid 90/150 CA engine: load a seed, run N parallel steps with optional
// XOR absorb, pulse done when the run finishes.
module ca_hybrid_engine
    import ca_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 8,
    parameter int BOUNDARY = BND_NULL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] rule,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             absorb_valid,
    input  logic [WIDTH-1:0] absorb_data,
    output logic [WIDTH-1:0] state,
    output logic             busy,
    output logic             done
);
    fsm_e             r_fsm;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_rule;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_left;
    logic [WIDTH-1:0] w_right;
    logic [WIDTH-1:0] w_next;

    // Edge cells see 0 (null) or the opposite end (periodic).
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            if (i == 0) begin : g_lo
                if (BOUNDARY == BND_PERIODIC) begin : g_wrap
                    assign w_left[i] = r_state[WIDTH-1];
                end else begin : g_null
                    assign w_left[i] = 1'b0;
                end
            end else begin : g_mid_l
                assign w_left[i] = r_state[i-1];
            end

            if (i == WIDTH-1) begin : g_hi
                if (BOUNDARY == BND_PERIODIC) begin : g_wrap
                    assign w_right[i] = r_state[0];
                end else begin : g_null
                    assign w_right[i] = 1'b0;
                end
            end else begin : g_mid_r
                assign w_right[i] = r_state[i+1];
            end

            ca_cell u_cell (
                .i_left  (w_left[i]),
                .i_self  (r_state[i]),
                .i_right (w_right[i]),
                .i_rule  (r_rule[i]),
                .o_next  (w_next[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_rule  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (load) begin
                        r_state <= seed;
                    end else if (start) begin
                        r_rule <= rule;
                        r_cnt  <= steps;
                        if (steps != '0) begin
                            r_fsm  <= RUN;
                            r_busy <= 1'b1;
                        end else begin
                            r_fsm  <= DONE;
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_state <= w_next ^ (absorb_valid ? absorb_data : '0);
                    r_cnt   <= r_cnt - CNT_W'(1);
                    // Counter holds the steps still to apply; this edge applies the last.
                    if (r_cnt == CNT_W'(1)) begin
                        r_fsm  <= DONE;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_done <= 1'b0;
                    r_fsm  <= IDLE;
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign state = r_state;
    assign busy  = r_busy;
    assign done  = r_done;
endmodule
